// File: rtl/if_id_buffer.sv
// Fetch-to-decode instruction FIFO with valid/ready on both sides.
// Head word is presented pre-split into RV32 fields; empty shows a NOP.
module if_id_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [31:0]                pc_i,
  input  logic [31:0]                instr_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [31:0]                pc_o,
  output logic [31:0]                instr_o,
  output logic [6:0]                 opcode_o,
  output logic [4:0]                 rd_o,
  output logic [2:0]                 funct3_o,
  output logic [4:0]                 rs1_o,
  output logic [4:0]                 rs2_o,
  output logic [6:0]                 funct7_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;

  assign full  = (count == FULL);
  assign empty = (count == '0);

  // Held low during reset so fetch cannot hand over a word mid-reset.
  assign ready_o = ~rst_i & ~full;
  assign valid_o = ~empty;

  assign push = valid_i & ready_o & ~flush_i;
  assign pop  = valid_o & ready_i & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (flush_i) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the empty mux hides stale contents.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: pc_i, instr: instr_i};
    end
  end

  always_comb begin
    head = mem[rd_ptr];
    if (empty) begin
      pc_o    = '0;
      instr_o = NOP_INSTR;
    end else begin
      pc_o    = head.pc;
      instr_o = head.instr;
    end
  end

  assign opcode_o = instr_o[6:0];
  assign rd_o     = instr_o[11:7];
  assign funct3_o = instr_o[14:12];
  assign rs1_o    = instr_o[19:15];
  assign rs2_o    = instr_o[24:20];
  assign funct7_o = instr_o[31:25];
  assign count_o  = count;

  a_count_bound: assert property (
    @(posedge clk_i) disable iff (rst_i) count <= FULL);
  a_no_push_full: assert property (
    @(posedge clk_i) disable iff (rst_i) !(push && full));
  a_no_pop_empty: assert property (
    @(posedge clk_i) disable iff (rst_i) !(pop && empty));

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_if_id_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 0;
  logic        rst_i = 1;
  logic        flush_i = 0;
  logic        valid_i = 0;
  logic        ready_o;
  logic [31:0] pc_i = 0;
  logic [31:0] instr_i = 0;
  logic        valid_o;
  logic        ready_i = 0;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [6:0]  opcode_o;
  logic [4:0]  rd_o;
  logic [2:0]  funct3_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [6:0]  funct7_o;
  logic [1:0]  count_o;

  if_id_buffer #(.DEPTH(2), .NOP_INSTR(NOP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .instr_i(instr_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .instr_o(instr_o),
    .opcode_o(opcode_o), .rd_o(rd_o), .funct3_o(funct3_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .funct7_o(funct7_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } word_t;

  word_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic cmp(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [99:0] dut_bundle();
    return {valid_o, ready_o, count_o, pc_o, instr_o, opcode_o, rd_o,
            funct3_o, rs1_o, rs2_o, funct7_o};
  endfunction

  // Expected outputs from the queue: fields by shift and mask.
  function automatic logic [99:0] model_bundle();
    logic [31:0] w, p;
    logic        v;
    v = (q.size() != 0);
    w = v ? q[0].instr : NOP;
    p = v ? q[0].pc : 32'd0;
    return {v, !rst_i && q.size() < 2, 2'(q.size()), p, w,
            7'(w & 32'h7F), 5'((w >> 7) & 32'h1F), 3'((w >> 12) & 32'h7),
            5'((w >> 15) & 32'h1F), 5'((w >> 20) & 32'h1F),
            7'((w >> 25) & 32'h7F)};
  endfunction

  task automatic step(input logic v, input logic [31:0] p,
                      input logic [31:0] ins, input logic r,
                      input logic f, input string nm);
    int sz;
    valid_i = v; pc_i = p; instr_i = ins; ready_i = r; flush_i = f;
    #1;
    cmp({nm, "_model"}, 128'(dut_bundle()), 128'(model_bundle()));
    sz = q.size();
    @(posedge clk_i);
    if (f) q.delete();
    else begin
      if (r && sz > 0) void'(q.pop_front());
      if (v && sz < 2) q.push_back('{pc: p, instr: ins});
    end
    @(negedge clk_i);
  endtask

  typedef struct {
    logic        v, r, f;
    logic [31:0] pc, instr;
    logic        ev, er;
    logic [1:0]  ec;
    logic [31:0] epc, einstr;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int sent;
    logic tog;
    logic [31:0] rcv[$];

    tbl[0]  = '{1,1,0, 32'h100, 32'h00A28293, 1,1,1, 32'h100, 32'h00A28293};
    tbl[1]  = '{0,1,0, 32'h0,   32'h0,        0,1,0, 32'h0,   NOP};
    tbl[2]  = '{1,0,0, 32'h100, 32'h00100093, 1,1,1, 32'h100, 32'h00100093};
    tbl[3]  = '{1,0,0, 32'h104, 32'h00208113, 1,0,2, 32'h100, 32'h00100093};
    tbl[4]  = '{1,0,0, 32'h108, 32'h00310193, 1,0,2, 32'h100, 32'h00100093};
    tbl[5]  = '{1,1,0, 32'h108, 32'h00310193, 1,1,1, 32'h104, 32'h00208113};
    tbl[6]  = '{1,1,0, 32'h108, 32'h00310193, 1,1,1, 32'h108, 32'h00310193};
    tbl[7]  = '{0,1,0, 32'h0,   32'h0,        0,1,0, 32'h0,   NOP};
    tbl[8]  = '{1,0,0, 32'h200, 32'h00400213, 1,1,1, 32'h200, 32'h00400213};
    tbl[9]  = '{1,1,1, 32'h204, 32'h00500293, 0,1,0, 32'h0,   NOP};
    tbl[10] = '{0,0,0, 32'h0,   32'h0,        0,1,0, 32'h0,   NOP};

    // Reset held across an edge
    #12;
    cmp("in_reset", 128'({valid_o, ready_o, count_o}), 128'(4'b0000));
    @(negedge clk_i);
    rst_i = 0;
    #1;
    cmp("reset_idle",
        128'({valid_o, ready_o, count_o, instr_o, opcode_o}),
        128'({1'b0, 1'b1, 2'd0, NOP, 7'h13}));

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].pc, tbl[i].instr, tbl[i].r, tbl[i].f,
           $sformatf("tbl%0d", i));
      cmp($sformatf("tbl%0d_exp", i),
          128'({valid_o, ready_o, count_o, pc_o, instr_o, opcode_o}),
          128'({tbl[i].ev, tbl[i].er, tbl[i].ec, tbl[i].epc,
                tbl[i].einstr, tbl[i].einstr[6:0]}));
      if (i == 0)
        cmp("fields",
            128'({rd_o, rs1_o, rs2_o, funct3_o, funct7_o}),
            128'({5'd5, 5'd5, 5'd10, 3'd0, 7'd0}));
    end

    // Wrap-around stream with decode toggling ready
    sent = 0;
    tog = 1;
    for (int c = 0; c < 200 && rcv.size() < 10; c++) begin
      logic acc;
      acc = (sent < 10) && ready_o;
      if (valid_o && tog) rcv.push_back(pc_o);
      step(sent < 10, 32'h400 + 32'(4 * sent), 32'h00000013 + 32'(sent << 7),
           tog, 0, "wrap");
      if (acc) sent++;
      tog = ~tog;
    end
    cmp("wrap_count", 128'(rcv.size()), 128'(10));
    foreach (rcv[k])
      cmp($sformatf("wrap_pc%0d", k), 128'(rcv[k]), 128'(32'h400 + 4 * k));

    // Async reset between edges with two entries held
    step(1, 32'h500, 32'h00600313, 0, 0, "pre_rst0");
    step(1, 32'h504, 32'h00700393, 0, 0, "pre_rst1");
    cmp("pre_rst_full", 128'(count_o), 128'(2));
    valid_i = 0; ready_i = 0;
    @(posedge clk_i);
    #3 rst_i = 1;
    q.delete();
    #1;
    cmp("async_rst",
        128'({valid_o, ready_o, count_o, pc_o, instr_o}),
        128'({1'b0, 1'b0, 2'd0, 32'd0, NOP}));
    @(negedge clk_i);
    rst_i = 0;
    #1;
    cmp("post_rst", 128'({valid_o, ready_o}), 128'(2'b01));
    for (int c = 0; c < 4; c++) step(0, 0, 0, 1, 0, "post_rst_idle");

    // Random traffic against the model
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, "rand");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
